id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised operand-resolution and issue stage between instruction decode and EX. It takes one decoded instruction per transfer, resolves both source operands from the register file, an immediate, or any of NUM_FWD forwarding sources, and stalls on operands that are not yet available. It tracks outstanding long-latency writes (divide, load miss) in a scoreboard and resolves movn/movz write-enables from forwarded data. Results go to EX through a registered valid/ready ID/EX boundary.

## Interface
- DATA_W, 32, operand/data width
- REG_ADDR_W, 5, register address width
- NUM_FWD, 2, forwarding sources; index 0 is youngest (EX), higher indices are older (MEM, ...)
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  decoded instruction present
- in_ready_o  out  1  stage accepts instruction this cycle
- in_re1_i / in_re2_i  in  1 each  read rs / rt
- in_ra1_i / in_ra2_i  in  REG_ADDR_W each  rs / rt address (also drives reg1_addr_o / reg2_addr_o)
- in_imm_i  in  DATA_W  immediate used when a read enable is low
- in_wd_i  in  REG_ADDR_W  destination
- in_wreg_i  in  1  writes destination
- in_wcond_i  in  2  00 unconditional, 01 write if op2≠0 (movn), 10 write if op2==0 (movz), 11 reserved (treated as 00)
- in_long_i  in  1  long-latency producer; result arrives via wb_done
- in_aluop_i  in  ALUOP_W;  in_alusel_i  in  ALUSEL_W
- reg1_addr_o / reg2_addr_o  out  REG_ADDR_W each  regfile read addresses
- reg1_data_i / reg2_data_i  in  DATA_W each  regfile read data (same cycle)
- fwd_wreg_i  in  NUM_FWD  source k writes
- fwd_wd_i  in  NUM_FWD*REG_ADDR_W  source k destination, packed, k=0 in LSBs
- fwd_wdata_i  in  NUM_FWD*DATA_W  source k data, packed
- fwd_rdy_i  in  NUM_FWD  source k data valid this cycle (0 = load in flight)
- wb_done_i  in  1;  wb_done_wd_i  in  REG_ADDR_W  long-latency write completed
- flush_i  in  1  discard the ID/EX register and the input instruction
- out_valid_o  out  1;  out_ready_i  in  1
- reg1_o / reg2_o  out  DATA_W;  wd_o  out  REG_ADDR_W;  wreg_o  out  1
- aluop_o  out  ALUOP_W;  alusel_o  out  ALUSEL_W
- stall_o  out  1  in_valid_i high and hazard blocks issue

## Operation
- Operand n: if re=0 → in_imm_i. If address=0 → 0, never hazards. Otherwise take the lowest k with fwd_wreg[k] and fwd_wd[k]==addr. If fwd_rdy[k] is 1, use fwd_wdata[k]; if 0, hazard. With no match, use regfile data.
- Scoreboard: pending[31:1] bits. Hazard if any read register (re=1, addr≠0) is pending. WAW hazard if in_wreg_i is 1 and pending[in_wd_i] is 1.
- Set pending[in_wd_i] on a transfer with in_long_i=1, in_wreg_i=1, in_wd_i≠0. Clear on wb_done_i.
- Set and clear of the same register in one cycle: set wins.
- Pending bits are registered. A clear becomes visible the next cycle, so a dependent instruction waits at least one cycle after wb_done.
- wreg_o = in_wreg_i gated by in_wcond_i, evaluated on the resolved op2.
- in_ready_o = !hazard && (!out_valid_o || out_ready_i) && !flush_i.
- Transfer occurs when in_valid_i && in_ready_o. The ID/EX register loads and out_valid_o is set to 1.
- If out_ready_i is high without a transfer, out_valid_o is cleared to 0. Otherwise the register holds.
- flush_i clears out_valid_o next cycle and blocks transfer. Pending bits are untouched, since outstanding operations still complete.

## Timing
- Reset: out_valid_o=0; reg1_o, reg2_o, wd_o, wreg_o, aluop_o, alusel_o all 0; pending all 0.
- in_ready_o and stall_o are combinational and 0 while rst is high.
- Latency is 1 cycle, input transfer to out_valid_o.
- Throughput is 1 per cycle with no hazards and out_ready_i held high.
- Reset asserted mid-stall drops the held instruction and the scoreboard.
- Output bundle holds stable while out_valid_o && !out_ready_i.

## Configuration
- ID_SCOREBOARD_EN defined: scoreboard present as above.
- ID_SCOREBOARD_EN undefined: no pending state. in_long_i, wb_done_i and wb_done_wd_i are ignored. Hazards come only from fwd_rdy_i.

## Structure
- Shared package: wcond encodings, NOPRegAddr, ZeroWord, and the default widths.
- One sub-module, id_scoreboard: pending bits, set/clear, and the hazard query for two read ports plus one write port.

## Test plan
- Back-to-back: ori r1,r0,5 then or r2,r1,r1 with fwd[0] matching r1=5, rdy=1 → reg1_o=reg2_o=5, no stall, outputs on consecutive cycles.
- Load-use: fwd[0] wd=3, rdy=0; next instruction reads r3 → stall_o=1 for one cycle. Then fwd[1] supplies 0xDEAD, rdy=1 → reg1_o=0xDEAD.
- Priority: fwd[0] and fwd[1] both write r4 with 0x11 / 0x22 → reg1_o=0x11.
- Scoreboard: long op to r7, reader of r7 stalls. wb_done_wd=7 at cycle t → reader issues at t+1. Simultaneous new long issue to r7 and done for r7 → pending stays set.
- movz with op2=0 → wreg_o=1; op2=0x1 → wreg_o=0. movn gives the inverse. Reads of r0 with fwd wd=0 → reg=0.
- Backpressure/flush: out_ready_i=0 for 3 cycles → output stable, in_ready_o=0. flush_i → out_valid_o=0 next cycle, pending unchanged.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared constants for the ID operand/issue stage.
// Default widths, write-condition encodings and common zero values.
package id_operand_stage_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int NUM_FWD_DEF    = 2;
  localparam int ALUOP_W_DEF    = 8;
  localparam int ALUSEL_W_DEF   = 3;

  typedef enum logic [1:0] {
    WCOND_ALWAYS = 2'b00,
    WCOND_MOVN   = 2'b01,
    WCOND_MOVZ   = 2'b10,
    WCOND_RSVD   = 2'b11
  } wcond_e;

  localparam logic [4:0]  NOPRegAddr = 5'b0;
  localparam logic [31:0] ZeroWord   = 32'h0;

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: pending-write bits for long-latency producers.
// Answers RAW (two read ports) and WAW (one write port) hazard queries.
module id_scoreboard
  import id_operand_stage_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_wd_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_wd_i,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  output logic                  hazard_o
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] R0 =
    REG_ADDR_W'(NOPRegAddr);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_d;
  logic            raw1;
  logic            raw2;
  logic            waw;

  // Clear applied first so a same-cycle set of that register wins.
  always_comb begin
    pending_d = pending;
    if (clr_i)
      pending_d[clr_wd_i] = 1'b0;
    if (set_i && set_wd_i != R0)
      pending_d[set_wd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_d;
  end

  assign raw1 = re1_i && (ra1_i != R0) && pending[ra1_i];
  assign raw2 = re2_i && (ra2_i != R0) && pending[ra2_i];
  assign waw  = we_i && pending[wd_i];

  assign hazard_o = raw1 || raw2 || waw;

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand resolution, hazard stall and ID/EX issue register.
// Define ID_SCOREBOARD_EN to track long-latency writes in id_scoreboard.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_FWD    = NUM_FWD_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int ALUSEL_W   = ALUSEL_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_re1_i,
  input  logic                          in_re2_i,
  input  logic [REG_ADDR_W-1:0]         in_ra1_i,
  input  logic [REG_ADDR_W-1:0]         in_ra2_i,
  input  logic [DATA_W-1:0]             in_imm_i,
  input  logic [REG_ADDR_W-1:0]         in_wd_i,
  input  logic                          in_wreg_i,
  input  logic [1:0]                    in_wcond_i,
  input  logic                          in_long_i,
  input  logic [ALUOP_W-1:0]            in_aluop_i,
  input  logic [ALUSEL_W-1:0]           in_alusel_i,
  output logic [REG_ADDR_W-1:0]         reg1_addr_o,
  output logic [REG_ADDR_W-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [NUM_FWD-1:0]            fwd_wreg_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_wdata_i,
  input  logic [NUM_FWD-1:0]            fwd_rdy_i,
  input  logic                          wb_done_i,
  input  logic [REG_ADDR_W-1:0]         wb_done_wd_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             reg1_o,
  output logic [DATA_W-1:0]             reg2_o,
  output logic [REG_ADDR_W-1:0]         wd_o,
  output logic                          wreg_o,
  output logic [ALUOP_W-1:0]            aluop_o,
  output logic [ALUSEL_W-1:0]           alusel_o,
  output logic                          stall_o
);

  localparam logic [REG_ADDR_W-1:0] R0 =
    REG_ADDR_W'(NOPRegAddr);
  localparam logic [DATA_W-1:0] ZW =
    DATA_W'(ZeroWord);

  typedef struct packed {
    logic              hz;
    logic [DATA_W-1:0] val;
  } opnd_t;

  opnd_t op1;
  opnd_t op2;
  logic  sb_hazard;
  logic  hazard;
  logic  xfer;
  logic  wreg_d;

  // Lowest-index forwarding source is youngest and wins.
  function automatic opnd_t resolve(
    input logic                  re,
    input logic [REG_ADDR_W-1:0] ra,
    input logic [DATA_W-1:0]     rf
  );
    opnd_t r;
    logic  hit;
    r.hz  = 1'b0;
    r.val = rf;
    hit   = 1'b0;
    if (!re) begin
      r.val = in_imm_i;
    end else if (ra == R0) begin
      r.val = ZW;
    end else begin
      for (int k = 0; k < NUM_FWD; k++) begin
        if (!hit && fwd_wreg_i[k] &&
            fwd_wd_i[k*REG_ADDR_W +: REG_ADDR_W] == ra) begin
          hit   = 1'b1;
          r.hz  = !fwd_rdy_i[k];
          r.val = fwd_wdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(in_re1_i, in_ra1_i, reg1_data_i);
    op2 = resolve(in_re2_i, in_ra2_i, reg2_data_i);
  end

  always_comb begin
    wreg_d = in_wreg_i;
    unique case (1'b1)
      in_wcond_i == WCOND_MOVN: wreg_d = in_wreg_i && (op2.val != ZW);
      in_wcond_i == WCOND_MOVZ: wreg_d = in_wreg_i && (op2.val == ZW);
      default:                  wreg_d = in_wreg_i;
    endcase
  end

`ifdef ID_SCOREBOARD_EN
  id_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_i    (xfer && in_long_i && in_wreg_i),
    .set_wd_i (in_wd_i),
    .clr_i    (wb_done_i),
    .clr_wd_i (wb_done_wd_i),
    .re1_i    (in_re1_i),
    .ra1_i    (in_ra1_i),
    .re2_i    (in_re2_i),
    .ra2_i    (in_ra2_i),
    .we_i     (in_wreg_i),
    .wd_i     (in_wd_i),
    .hazard_o (sb_hazard)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{in_long_i, wb_done_i, wb_done_wd_i};
  assign sb_hazard = 1'b0;
`endif

  assign hazard = op1.hz || op2.hz || sb_hazard;

  assign in_ready_o = !rst && !hazard &&
                      (!out_valid_o || out_ready_i) && !flush_i;
  assign stall_o    = !rst && in_valid_i && hazard;
  assign xfer       = in_valid_i && in_ready_o;

  assign reg1_addr_o = in_ra1_i;
  assign reg2_addr_o = in_ra2_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      reg1_o      <= '0;
      reg2_o      <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      aluop_o     <= '0;
      alusel_o    <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      reg1_o      <= op1.val;
      reg2_o      <= op2.val;
      wd_o        <= in_wd_i;
      wreg_o      <= wreg_d;
      aluop_o     <= in_aluop_i;
      alusel_o    <= in_alusel_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed plus random stimulus for id_operand_stage,
// checked every cycle against a rule-level model of the stage.
module tb_id_operand_stage;

  localparam int NF = 2;
`ifdef ID_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        re1, re2;
  logic [4:0]  ra1, ra2;
  logic [31:0] imm;
  logic [4:0]  wd;
  logic        wreg;
  logic [1:0]  wcond;
  logic        long_op;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic [NF-1:0]    fwd_wreg;
  logic [NF*5-1:0]  fwd_wd;
  logic [NF*32-1:0] fwd_wdata;
  logic [NF-1:0]    fwd_rdy;
  logic        wb_done;
  logic [4:0]  wb_wd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic        stall;

  logic        f_wreg [NF];
  logic [4:0]  f_wd   [NF];
  logic [31:0] f_data [NF];
  logic        f_rdy  [NF];
  logic [31:0] rf     [32];

  int checks   = 0;
  int failures = 0;

  bit          m_valid;
  logic [31:0] m_r1, m_r2;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  bit          m_pend [32];
  logic        s_stall, s_ready;

  id_operand_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_re1_i     (re1),
    .in_re2_i     (re2),
    .in_ra1_i     (ra1),
    .in_ra2_i     (ra2),
    .in_imm_i     (imm),
    .in_wd_i      (wd),
    .in_wreg_i    (wreg),
    .in_wcond_i   (wcond),
    .in_long_i    (long_op),
    .in_aluop_i   (aluop),
    .in_alusel_i  (alusel),
    .reg1_addr_o  (reg1_addr),
    .reg2_addr_o  (reg2_addr),
    .reg1_data_i  (reg1_data),
    .reg2_data_i  (reg2_data),
    .fwd_wreg_i   (fwd_wreg),
    .fwd_wd_i     (fwd_wd),
    .fwd_wdata_i  (fwd_wdata),
    .fwd_rdy_i    (fwd_rdy),
    .wb_done_i    (wb_done),
    .wb_done_wd_i (wb_wd),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .reg1_o       (reg1_o),
    .reg2_o       (reg2_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .aluop_o      (aluop_o),
    .alusel_o     (alusel_o),
    .stall_o      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fwd_wreg  = '0;
    fwd_wd    = '0;
    fwd_wdata = '0;
    fwd_rdy   = '0;
    for (int k = 0; k < NF; k++) begin
      fwd_wreg[k]         = f_wreg[k];
      fwd_wd[k*5 +: 5]    = f_wd[k];
      fwd_wdata[k*32 +: 32] = f_data[k];
      fwd_rdy[k]          = f_rdy[k];
    end
  end

  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void resolve(input logic re, input logic [4:0] ra,
                                  output logic [31:0] v, output logic hz);
    bit found = 0;
    hz = 1'b0;
    if (!re) begin
      v = imm;
      return;
    end
    if (ra == 5'd0) begin
      v = 32'd0;
      return;
    end
    v = rf[ra];
    for (int k = 0; k < NF; k++)
      if (!found && f_wreg[k] && f_wd[k] == ra) begin
        found = 1;
        v     = f_data[k];
        hz    = !f_rdy[k];
      end
    if (m_pend[ra]) hz = 1'b1;
  endfunction

  // One cycle: inputs are already set just after a falling edge.
  task automatic step();
    logic [31:0] o1, o2;
    logic h1, h2, hz, e_wr, e_rdy, e_stall, xf;
    #1;
    resolve(re1, ra1, o1, h1);
    resolve(re2, ra2, o2, h2);
    hz = h1 || h2 || (wreg && m_pend[wd]);
    case (wcond)
      2'b01:   e_wr = wreg && (o2 != 0);
      2'b10:   e_wr = wreg && (o2 == 0);
      default: e_wr = wreg;
    endcase
    e_rdy   = !rst && !hz && (!m_valid || out_ready) && !flush;
    e_stall = !rst && in_valid && hz;
    chk("in_ready", in_ready, e_rdy);
    chk("stall", stall, e_stall);
    chk("reg1_addr", reg1_addr, ra1);
    chk("reg2_addr", reg2_addr, ra2);
    s_stall = stall;
    s_ready = in_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_r1 = 0; m_r2 = 0; m_wd = 0;
      m_wreg = 0; m_aluop = 0; m_alusel = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      xf = in_valid && e_rdy;
      if (SB) begin
        if (wb_done) m_pend[wb_wd] = 0;
        if (xf && long_op && wreg && wd != 0) m_pend[wd] = 1;
      end
      if (flush) m_valid = 0;
      else if (xf) begin
        m_valid = 1; m_r1 = o1; m_r2 = o2; m_wd = wd;
        m_wreg = e_wr; m_aluop = aluop; m_alusel = alusel;
      end else if (out_ready) m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("reg1_o", reg1_o, m_r1);
    chk("reg2_o", reg2_o, m_r2);
    chk("wd_o", wd_o, m_wd);
    chk("wreg_o", wreg_o, m_wreg);
    chk("aluop_o", aluop_o, m_aluop);
    chk("alusel_o", alusel_o, m_alusel);
  endtask

  task automatic idle();
    in_valid = 0; re1 = 0; re2 = 0; ra1 = 0; ra2 = 0; imm = 0;
    wd = 0; wreg = 0; wcond = 0; long_op = 0; aluop = 0; alusel = 0;
    wb_done = 0; wb_wd = 0; flush = 0; out_ready = 1;
    for (int k = 0; k < NF; k++) begin
      f_wreg[k] = 0; f_wd[k] = 0; f_data[k] = 0; f_rdy[k] = 1;
    end
  endtask

  task automatic set_ins(input logic r1e, input logic [4:0] a1,
                         input logic r2e, input logic [4:0] a2,
                         input logic [31:0] im, input logic [4:0] d,
                         input logic w);
    in_valid = 1; re1 = r1e; ra1 = a1; re2 = r2e; ra2 = a2;
    imm = im; wd = d; wreg = w;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_r1 = 0; m_r2 = 0; m_wd = 0;
    m_wreg = 0; m_aluop = 0; m_alusel = 0;
    idle();
    rst = 1;
    f_wreg[0] = 1; f_wd[0] = 3; f_rdy[0] = 0;
    set_ins(1, 3, 0, 0, 0, 1, 1);
    step();
    chk("rst_stall", s_stall, 0);
    chk("rst_ready", s_ready, 0);
    rst = 0;
    idle();
    step();

    // back-to-back: ori r1,r0,5 ; or r2,r1,r1
    set_ins(1, 0, 0, 0, 32'd5, 1, 1);
    aluop = 8'h0d; alusel = 3'd1;
    step();
    chk("ori_valid", out_valid, 1);
    chk("ori_reg2", reg2_o, 32'd5);
    set_ins(1, 1, 1, 1, 0, 2, 1);
    f_wreg[0] = 1; f_wd[0] = 1; f_data[0] = 32'd5; f_rdy[0] = 1;
    step();
    chk("b2b_stall", s_stall, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_reg1", reg1_o, 32'd5);
    chk("b2b_reg2", reg2_o, 32'd5);

    // load-use
    idle();
    f_wreg[0] = 1; f_wd[0] = 3; f_rdy[0] = 0;
    set_ins(1, 3, 0, 0, 0, 4, 1);
    step();
    chk("lu_stall", s_stall, 1);
    chk("lu_valid", out_valid, 0);
    f_wreg[0] = 0;
    f_wreg[1] = 1; f_wd[1] = 3; f_data[1] = 32'hDEAD; f_rdy[1] = 1;
    step();
    chk("lu_stall2", s_stall, 0);
    chk("lu_reg1", reg1_o, 32'hDEAD);

    // forwarding priority
    idle();
    f_wreg[0] = 1; f_wd[0] = 4; f_data[0] = 32'h11;
    f_wreg[1] = 1; f_wd[1] = 4; f_data[1] = 32'h22;
    set_ins(1, 4, 0, 0, 0, 5, 1);
    step();
    chk("prio_reg1", reg1_o, 32'h11);

    // movz / movn
    idle();
    set_ins(0, 0, 0, 0, 32'd0, 6, 1); wcond = 2'b10;
    step();
    chk("movz0", wreg_o, 1);
    imm = 32'd1;
    step();
    chk("movz1", wreg_o, 0);
    wcond = 2'b01;
    step();
    chk("movn1", wreg_o, 1);
    imm = 32'd0;
    step();
    chk("movn0", wreg_o, 0);
    wcond = 2'b11;
    step();
    chk("wc_rsvd", wreg_o, 1);

    // r0 with a forwarding source naming r0
    idle();
    f_wreg[0] = 1; f_wd[0] = 0; f_data[0] = 32'hBAD; f_rdy[0] = 0;
    set_ins(1, 0, 1, 0, 0, 1, 1);
    step();
    chk("r0_stall", s_stall, 0);
    chk("r0_reg1", reg1_o, 0);
    chk("r0_reg2", reg2_o, 0);

    // backpressure
    idle();
    step();
    set_ins(0, 0, 0, 0, 32'h77, 3, 1); out_ready = 0;
    step();
    chk("bp_load", reg2_o, 32'h77);
    imm = 32'h88;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", s_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", reg2_o, 32'h77);
    end
    out_ready = 1;
    step();
    chk("bp_next", reg2_o, 32'h88);

    // flush
    imm = 32'h99; flush = 1;
    step();
    chk("fl_ready", s_ready, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_hold", reg2_o, 32'h88);

`ifdef ID_SCOREBOARD_EN
    idle();
    set_ins(0, 0, 0, 0, 0, 7, 1); long_op = 1;
    step();
    long_op = 0;
    set_ins(1, 7, 0, 0, 0, 8, 1);
    step();
    chk("sb_stall_a", s_stall, 1);
    wb_done = 1; wb_wd = 7;
    step();
    chk("sb_stall_t", s_stall, 1);
    wb_done = 0;
    step();
    chk("sb_issue", s_stall, 0);
    chk("sb_reg1", reg1_o, 32'h1007);
    idle();
    set_ins(0, 0, 0, 0, 0, 7, 1); long_op = 1;
    wb_done = 1; wb_wd = 7;
    step();
    idle();
    set_ins(1, 7, 0, 0, 0, 8, 1); flush = 1;
    step();
    flush = 0;
    step();
    chk("sb_setwins", s_stall, 1);
    wb_done = 1; wb_wd = 7;
    step();
    wb_done = 0;
    step();
`else
    idle();
    set_ins(0, 0, 0, 0, 0, 7, 1); long_op = 1;
    step();
    long_op = 0;
    set_ins(1, 7, 0, 0, 0, 8, 1);
    step();
    chk("nosb_stall", s_stall, 0);
`endif

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst       = (i % 700 == 350);
      in_valid  = ($urandom_range(0, 9) < 8);
      re1       = $urandom_range(0, 1);
      re2       = $urandom_range(0, 1);
      ra1       = 5'($urandom_range(0, 7));
      ra2       = 5'($urandom_range(0, 7));
      imm       = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      wd        = 5'($urandom_range(0, 7));
      wreg      = $urandom_range(0, 1);
      wcond     = 2'($urandom_range(0, 3));
      long_op   = ($urandom_range(0, 7) == 0);
      aluop     = 8'($urandom);
      alusel    = 3'($urandom);
      wb_done   = ($urandom_range(0, 3) == 0);
      wb_wd     = 5'($urandom_range(1, 7));
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NF; k++) begin
        f_wreg[k] = $urandom_range(0, 1);
        f_wd[k]   = 5'($urandom_range(0, 7));
        f_data[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        f_rdy[k]  = ($urandom_range(0, 6) != 0);
      end
      if (i % 100 == 0)
        for (int r = 1; r < 32; r++)
          rf[r] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
